// File: rtl/round_key_server.sv
// Round-key server: captures a full AES-256 key schedule in one cycle and streams
// it to the cipher core over valid/ready, forward or reversed, with optional InvMixColumns.
module round_key_server #(
  parameter int          NUM_KEYS  = 15,
  parameter int unsigned EQUIV_INV = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [NUM_KEYS*128-1:0] key_in,
  input  logic                    start,
  input  logic                    decrypt,
  input  logic                    rk_ready,
  output logic [127:0]            rk_out,
  output logic [3:0]              rk_round,
  output logic                    rk_valid,
  output logic                    rk_last,
  output logic                    loaded,
  output logic                    busy
);

  localparam logic [3:0] LAST = 4'(NUM_KEYS - 1);

  typedef enum logic [1:0] {EMPTY = 2'd0, LOADED = 2'd1, STREAM = 2'd2} state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q [NUM_KEYS];
  logic [127:0] key_d [NUM_KEYS];
  logic         mode_q, mode_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] rk_out_q, rk_out_d;

  logic         capture, go, xfer, advance, nxt_mode;
  logic [3:0]   nxt_n, rk_idx;
  logic [127:0] raw_key;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiples 9/b/d/e are built from the doubling chain x2, x4, x8.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0]  a [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] o;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    o = '0;
    for (int r = 0; r < 4; r++) begin
      o[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r])
                     ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                     ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                     ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] k);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 4; i++) o[127-32*i -: 32] = inv_mix_col(k[127-32*i -: 32]);
    return o;
  endfunction

  assign capture = key_valid && (state_q != STREAM);
  assign go      = (state_q == LOADED) && start && !key_valid;
  assign xfer    = (state_q == STREAM) && rk_ready;
  assign advance = xfer && (cnt_q != LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= EMPTY;
      // NOTE: the key file is cleared on reset because a reset must discard the held schedule.
      for (int i = 0; i < NUM_KEYS; i++) key_q[i] <= '0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      rk_out_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q  <= state_d;
      key_q    <= key_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      rk_out_q <= rk_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (key_valid) state_d = LOADED;
      LOADED:  if (go) state_d = STREAM;
      STREAM:  if (xfer && (cnt_q == LAST)) state_d = LOADED;
      default: state_d = EMPTY;
    endcase
  end

  // The next beat's key is selected and transformed ahead of time so rk_out is a plain flop.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch behind.
    key_d    = key_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    rk_out_d = rk_out_q;
    nxt_n    = go ? 4'd0 : cnt_q + 4'd1;
    nxt_mode = go ? decrypt : mode_q;
    rk_idx   = nxt_mode ? LAST - nxt_n : nxt_n;
    raw_key  = key_q[rk_idx];
    if (capture) begin
      for (int i = 0; i < NUM_KEYS; i++) key_d[i] = key_in[128*i +: 128];
    end
    if (go || advance) begin
      cnt_d    = nxt_n;
      mode_d   = nxt_mode;
      rk_out_d = ((EQUIV_INV != 0) && nxt_mode && (nxt_n != 4'd0) && (nxt_n != LAST))
                 ? inv_mix(raw_key) : raw_key;
    end
  end

  always_comb begin
    rk_valid = (state_q == STREAM);
    busy     = (state_q == STREAM);
    loaded   = (state_q != EMPTY);
    rk_last  = (state_q == STREAM) && (cnt_q == LAST);
    rk_round = cnt_q;
    rk_out   = rk_out_q;
  end

endmodule

// File: tb/tb_round_key_server.sv
// Bench for round_key_server: two instances (plain and equivalent-inverse keys) run in
// lockstep against a queue-based schedule model and a table of known-answer streams.
module tb_round_key_server;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           key_valid = 1'b0;
  logic [1919:0]  key_in = '0;
  logic           start = 1'b0;
  logic           decrypt = 1'b0;
  logic           rk_ready = 1'b0;

  logic [127:0] o0_out, o1_out;
  logic [3:0]   o0_round, o1_round;
  logic         o0_valid, o1_valid, o0_last, o1_last;
  logic         o0_loaded, o1_loaded, o0_busy, o1_busy;

  int checks = 0;
  int errors = 0;

  logic [127:0] mk [15];
  logic [127:0] exp0 [15];
  logic [127:0] exp1 [15];
  logic [127:0] seen_b0_0, seen_b1_0, seen_b1_1;

  typedef struct {
    int           pat;
    bit           dec;
    int           stall_beat;
    int           stall_len;
    bit           kv_pulse;
    bit           chk;
    logic [127:0] exp_b0;
    logic [127:0] exp_b1_eq0;
    logic [127:0] exp_b1_eq1;
  } vec_t;

  vec_t vecs [7];

  round_key_server #(.NUM_KEYS(15), .EQUIV_INV(0)) dut0 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in), .start(start),
    .decrypt(decrypt), .rk_ready(rk_ready), .rk_out(o0_out), .rk_round(o0_round),
    .rk_valid(o0_valid), .rk_last(o0_last), .loaded(o0_loaded), .busy(o0_busy)
  );

  round_key_server #(.NUM_KEYS(15), .EQUIV_INV(1)) dut1 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in), .start(start),
    .decrypt(decrypt), .rk_ready(rk_ready), .rk_out(o1_out), .rk_round(o1_round),
    .rk_valid(o1_valid), .rk_last(o1_last), .loaded(o1_loaded), .busy(o1_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // GF(2^8) multiply by shift-and-add, reduction polynomial 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_mix_ref(input logic [127:0] k);
    logic [7:0]   m [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] o = '0;
    logic [7:0]   acc;
    for (int col = 0; col < 4; col++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int c = 0; c < 4; c++)
          acc ^= gmul(m[(c - r + 4) % 4], k[127 - 32*col - 8*c -: 8]);
        o[127 - 32*col - 8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic build_exp(input bit dec);
    logic [127:0] q [$];
    q = {};
    for (int i = 0; i < 15; i++) begin
      if (dec) q.push_front(mk[i]);
      else     q.push_back(mk[i]);
    end
    for (int n = 0; n < 15; n++) begin
      exp0[n] = q[n];
      exp1[n] = (dec && n > 0 && n < 14) ? inv_mix_ref(q[n]) : q[n];
    end
  endtask

  task automatic fill_keys(input int pat);
    for (int i = 0; i < 15; i++) begin
      case (pat)
        0:       mk[i] = {16{8'(i + 32)}};
        1:       mk[i] = {16{8'(i)}};
        2:       mk[i] = {4{32'h01000000}};
        default: mk[i] = {$urandom, $urandom, $urandom, $urandom};
      endcase
    end
    if (pat == 0) begin
      mk[0] = 128'h12121212696969693434343434343434;
      mk[1] = 128'h56565656565656567878787878787878;
      mk[8] = 128'h981ccf1e5edf501fb532e109b536b9cf;
    end
  endtask

  task automatic load_keys();
    for (int i = 0; i < 15; i++) key_in[128*i +: 128] = mk[i];
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check("loaded_after_capture0", 128'(o0_loaded), 128'd1);
    check("loaded_after_capture1", 128'(o1_loaded), 128'd1);
  endtask

  task automatic run_stream(input bit dec, input int stall_beat, input int stall_len,
                            input bit kv_pulse);
    int n = 0;
    int stalls = 0;
    int cyc = 0;
    bit pulsed = 1'b0;
    build_exp(dec);
    start = 1'b1; decrypt = dec; rk_ready = 1'b1;
    tick();
    start = 1'b0; decrypt = 1'($urandom);
    while (n < 15 && cyc < 100) begin
      check("valid0", 128'(o0_valid), 128'd1);
      check("valid1", 128'(o1_valid), 128'd1);
      check("round0", 128'(o0_round), 128'(n));
      check("round1", 128'(o1_round), 128'(n));
      check("last0",  128'(o0_last),  128'(n == 14));
      check("out0",   o0_out, exp0[n]);
      check("out1",   o1_out, exp1[n]);
      if (n == 0) seen_b0_0 = o0_out;
      if (n == 1) begin seen_b1_0 = o0_out; seen_b1_1 = o1_out; end
      if (n == stall_beat && stalls < stall_len) begin
        rk_ready = 1'b0; stalls++;
      end else begin
        rk_ready = 1'b1;
      end
      if (kv_pulse && n == 3 && !pulsed) begin
        key_valid = 1'b1; pulsed = 1'b1;
        for (int i = 0; i < 15; i++) key_in[128*i +: 128] = ~mk[i];
      end else begin
        key_valid = 1'b0;
      end
      tick();
      cyc++;
      if (rk_ready) n++;
    end
    key_valid = 1'b0; rk_ready = 1'b0;
    check("transfers", 128'(n), 128'd15);
    check("end_valid0", 128'(o0_valid), 128'd0);
    check("end_busy0",  128'(o0_busy),  128'd0);
    check("end_loaded0", 128'(o0_loaded), 128'd1);
    check("end_valid1", 128'(o1_valid), 128'd0);
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, -1, 0, 1'b0, 1'b1,
                128'h12121212696969693434343434343434,
                128'h56565656565656567878787878787878,
                128'h56565656565656567878787878787878};
    vecs[1] = '{1, 1'b1, -1, 0, 1'b0, 1'b1,
                {16{8'h0e}}, {16{8'h0d}}, {16{8'h0d}}};
    vecs[2] = '{2, 1'b1, -1, 0, 1'b0, 1'b1,
                {4{32'h01000000}}, {4{32'h01000000}}, {4{32'h0e090d0b}}};
    vecs[3] = '{2, 1'b0, -1, 0, 1'b0, 1'b1,
                {4{32'h01000000}}, {4{32'h01000000}}, {4{32'h01000000}}};
    vecs[4] = '{3, 1'b1, 5, 3, 1'b1, 1'b0, '0, '0, '0};
    vecs[5] = '{3, 1'b0, 0, 2, 1'b1, 1'b0, '0, '0, '0};
    vecs[6] = '{3, 1'b1, 14, 2, 1'b0, 1'b0, '0, '0, '0};

    tick(); tick();
    check("rst_valid0",  128'(o0_valid),  128'd0);
    check("rst_loaded0", 128'(o0_loaded), 128'd0);
    check("rst_busy0",   128'(o0_busy),   128'd0);
    check("rst_last0",   128'(o0_last),   128'd0);
    check("rst_round0",  128'(o0_round),  128'd0);
    check("rst_out0",    o0_out, 128'd0);
    check("rst_out1",    o1_out, 128'd0);
    rst = 1'b1;

    start = 1'b1; tick(); start = 1'b0; tick();
    check("empty_start_valid", 128'(o0_valid),  128'd0);
    check("empty_start_loaded", 128'(o0_loaded), 128'd0);

    for (int v = 0; v < 7; v++) begin
      fill_keys(vecs[v].pat);
      load_keys();
      run_stream(vecs[v].dec, vecs[v].stall_beat, vecs[v].stall_len, vecs[v].kv_pulse);
      if (vecs[v].chk) begin
        check("tbl_beat0",     seen_b0_0, vecs[v].exp_b0);
        check("tbl_beat1_eq0", seen_b1_0, vecs[v].exp_b1_eq0);
        check("tbl_beat1_eq1", seen_b1_1, vecs[v].exp_b1_eq1);
      end
    end

    for (int r = 0; r < 4; r++) begin
      fill_keys(3);
      load_keys();
      run_stream(1'($urandom), int'($urandom_range(0, 14)), int'($urandom_range(0, 3)),
                 1'($urandom));
      // Back-to-back: a second stream starts the cycle right after the final transfer.
      run_stream(1'($urandom), -1, 0, 1'b0);
    end

    fill_keys(1);
    load_keys();
    fill_keys(3);
    for (int i = 0; i < 15; i++) key_in[128*i +: 128] = mk[i];
    key_valid = 1'b1; start = 1'b1;
    tick();
    key_valid = 1'b0; start = 1'b0;
    check("cap_wins_valid",  128'(o0_valid),  128'd0);
    check("cap_wins_loaded", 128'(o0_loaded), 128'd1);
    tick();
    check("cap_wins_idle", 128'(o0_valid), 128'd0);
    run_stream(1'b0, -1, 0, 1'b0);

    start = 1'b1; decrypt = 1'b0; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("pre_rst_round", 128'(o0_round), 128'd7);
    rst = 1'b0;
    tick();
    rst = 1'b1; rk_ready = 1'b0;
    check("mid_rst_valid0",  128'(o0_valid),  128'd0);
    check("mid_rst_loaded0", 128'(o0_loaded), 128'd0);
    check("mid_rst_busy0",   128'(o0_busy),   128'd0);
    check("mid_rst_out0",    o0_out, 128'd0);
    check("mid_rst_valid1",  128'(o1_valid),  128'd0);
    start = 1'b1; tick(); start = 1'b0; tick();
    check("post_rst_start_valid", 128'(o0_valid), 128'd0);
    check("post_rst_start_busy",  128'(o0_busy),  128'd0);
    fill_keys(3);
    load_keys();
    run_stream(1'b1, 7, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
